// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared constants and width helper for the stream round-robin arbiter
package stream_arb_pkg;

  localparam int STAT_W = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] idx;

  // Walk ptr+1, ptr+2, ... wrapping; the first asserted request wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - N-to-1 round-robin stream arbiter with a registered output stage
// Optional per-requester grant counters on output stat_grants when STREAM_ARB_STATS_EN is defined.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_W-1:0]               out_id
`ifdef STREAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]     stat_grants
`endif
);

  logic [ID_W-1:0] ptr;
  logic            grant_valid;
  logic [ID_W-1:0] grant_idx;
  logic            can_load;
  logic            accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req         (in_valid),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign can_load = !out_valid || out_ready;
  // Ready is derived from valid and the stage only, never from payload.
  assign accept   = !rst && can_load && grant_valid;
  assign in_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      ptr       <= ID_W'(NUM_REQ - 1);
    end else if (can_load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_id <= grant_idx;
        ptr    <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      out_data <= in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef STREAM_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (accept && grant_idx == ID_W'(i) && cnt != '1) begin
        cnt <= cnt + STAT_W'(1);
      end
    end

    assign stat_grants[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - scoreboard bench for stream_rr_arbiter against a queue-based reference model
module tb_stream_rr_arbiter;
  import stream_arb_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [IDW-1:0]  out_id;
`ifdef STREAM_ARB_STATS_EN
  logic [N*STAT_W-1:0] stat_grants;
`endif

  stream_rr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id)
`ifdef STREAM_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            id;
  } item_t;

  int         checks = 0;
  int         errors = 0;
  item_t      sb[$];
  int         seen_ids[$];
  int         m_ptr;
  int         grants[N];
  logic [N-1:0] exp_ready = '0;
  logic       mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner = valid requester at the smallest forward distance past the last grant.
  function automatic int pick(input logic [N-1:0] v, input int p);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - p - 1 + 2*N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic int seen(input int i);
    return (i < seen_ids.size()) ? seen_ids[i] : -1;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic rd);
    int    w;
    logic  can;
    item_t it;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = rd;
    can = (sb.size() == 0) || rd;
    w   = pick(v, m_ptr);
    exp_ready = (!r && can && w >= 0) ? (N'(1) << w) : '0;
    @(posedge clk);
    if (r) begin
      sb.delete();
      m_ptr = N - 1;
      for (int i = 0; i < N; i++) grants[i] = 0;
    end else if (exp_ready != '0) begin
      it.data = d[w*DW +: DW];
      it.id   = w;
      sb.push_back(it);
      m_ptr = w;
      if (grants[w] < 65535) grants[w]++;
    end
    #1;
  endtask

  function automatic logic [N*DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: held item must match the oldest expected item; pop on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (out_valid && sb.size() > 0) begin
        check("out_data", 64'(out_data), 64'(sb[0].data));
        check("out_id", 64'(out_id), 64'(sb[0].id));
        if (out_ready) begin
          seen_ids.push_back(int'(out_id));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N*DW-1:0] d;
    m_ptr = N - 1;
    for (int i = 0; i < N; i++) grants[i] = 0;

    step(1'b1, '0, '0, 1'b0);
    mon_en = 1'b1;
    step(1'b1, '0, '0, 1'b0);

    // Fairness from reset with everyone requesting.
    seen_ids.delete();
    for (int i = 0; i < 7; i++) step(1'b0, 4'b1111, rand_data(), 1'b1);
    check("fair_id0", 64'(seen(0)), 64'd0);
    check("fair_id1", 64'(seen(1)), 64'd1);
    check("fair_id2", 64'(seen(2)), 64'd2);
    check("fair_id3", 64'(seen(3)), 64'd3);
    check("fair_id4", 64'(seen(4)), 64'd0);
    check("fair_id5", 64'(seen(5)), 64'd1);

    // Backpressure holding a known payload.
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    d = rand_data();
    d[DW-1:0] = 32'hA5A5_A5A5;
    step(1'b0, 4'b0001, d, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, rand_data(), 1'b0);
    check("bp_data", 64'(out_data), 64'hA5A5_A5A5);
    seen_ids.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, rand_data(), 1'b1);
    check("bp_next_id", 64'(seen(1)), 64'd1);

    // Sparse requests and idle drain.
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    seen_ids.delete();
    step(1'b0, 4'b0010, rand_data(), 1'b1);
    step(1'b0, 4'b1010, rand_data(), 1'b1);
    step(1'b0, 4'b0010, rand_data(), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check("sparse_a", 64'(seen(0)), 64'd1);
    check("sparse_b", 64'(seen(1)), 64'd3);
    check("sparse_c", 64'(seen(2)), 64'd1);
    check("drain_valid", 64'(out_valid), 64'd0);

    // Reset while an item is held.
    step(1'b0, 4'b0100, rand_data(), 1'b0);
    step(1'b0, 4'b0100, rand_data(), 1'b0);
    step(1'b1, 4'b1111, rand_data(), 1'b0);
    check("rst_valid", 64'(out_valid), 64'd0);
    seen_ids.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, rand_data(), 1'b1);
    check("rst_first_id", 64'(seen(0)), 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0, N'($urandom), rand_data(), $urandom_range(9) < 7);
    end

`ifdef STREAM_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check("stat_rand", 64'(stat_grants[i*STAT_W +: STAT_W]), 64'(grants[i]));
    step(1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b0, 4'b0100, rand_data(), 1'b1);
    check("stat_sat2", 64'(stat_grants[2*STAT_W +: STAT_W]), 64'hFFFF);
    for (int i = 0; i < N; i++)
      check("stat_sat", 64'(stat_grants[i*STAT_W +: STAT_W]), 64'(grants[i]));
`endif

    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width in bits.
REQ-003 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  NUM_REQ*DATA_WIDTH: requester payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port in_valid  input  NUM_REQ: per-requester valid.
REQ-007 SHALL have port in_ready  output  NUM_REQ: per-requester ready.
REQ-008 SHALL have port out_data  output  DATA_WIDTH: registered payload.
REQ-009 SHALL have port out_valid  output  1: output holds an item.
REQ-010 SHALL have port out_ready  input  1: consumer accepts the item.
REQ-011 SHALL have port out_id  output  ID_W = max(1,$clog2(NUM_REQ)): index of the requester that sourced out_data.

Function
REQ-012 SHALL contain a one-entry output stage (data, id, valid); stage can load when !out_valid || out_ready.
REQ-013 SHALL pick a winner round-robin among asserted in_valid bits, searching from ptr+1 upward and wrapping modulo NUM_REQ.
REQ-014 SHALL assert in_ready[w] only for winner w, and only when the stage can load; all other in_ready bits SHALL be 0.
REQ-015 SHALL, on in_valid[w] && in_ready[w], load in_data[w] and w into the stage and set out_valid on the next edge (1-cycle latency).
REQ-016 SHALL set ptr <= w only on an accepted input transfer; ptr SHALL hold on stall or idle.
REQ-017 SHALL, if the stage can load but no in_valid is set, clear out_valid on the next edge.
REQ-018 SHALL hold out_data and out_id stable while out_valid && !out_ready.
REQ-019 SHALL sustain one transfer per cycle when out_ready is held high (full throughput through the stage).
REQ-020 SHALL let a single valid requester win every cycle regardless of ptr.
REQ-021 SHALL keep in_ready free of any combinational dependence on in_data.

Reset
REQ-022 SHALL, while rst is high at a clock edge, set out_valid=0, out_id=0, ptr=NUM_REQ-1 (requester 0 wins first) and clear the statistics counters.
REQ-023 SHALL drive all in_ready bits to 0 while rst is high; out_data is undefined after reset.
REQ-024 SHALL drop any item held in the stage when rst is asserted mid-operation; no transfer occurs in that cycle.

Configuration
REQ-025 SHALL, with STREAM_ARB_STATS_EN defined, add output stat_grants (NUM_REQ*16 bits): per-requester 16-bit counters that increment on each accepted transfer and saturate at 0xFFFF.
REQ-026 SHALL, without STREAM_ARB_STATS_EN, have no stat_grants port and no counter logic, with all other behaviour identical.

Structure
REQ-027 SHALL place the ID_W computation function and the constant STAT_W=16 in package stream_arb_pkg.
REQ-028 SHALL implement the winner search as combinational sub-module rr_pick (inputs req, ptr; outputs grant_valid, grant_idx), instantiated once.

Verification
REQ-029 SHALL test fairness: NUM_REQ=4, all in_valid=1, out_ready=1 from reset -> out_id sequence 0,1,2,3,0,1 with out_valid high every cycle after the first.
REQ-030 SHALL test backpressure: out_ready=0 for 5 cycles with out_valid=1, out_data=0xA5A5A5A5 -> data and id unchanged, in_ready=0000, ptr unchanged; the next grant after out_ready rises follows ptr.
REQ-031 SHALL test a sparse request set: in_valid=1010, ptr=1 -> grant 3; then in_valid=0010 -> grant 1; out_id follows one cycle later.
REQ-032 SHALL test reset mid-stream: rst asserted while out_valid=1 -> out_valid=0 the next cycle; after release with in_valid=1111, the first out_id=0.
REQ-033 SHALL test statistics with STREAM_ARB_STATS_EN: 70000 accepted transfers from requester 2 only -> stat_grants[2]=0xFFFF and all other counters 0.
REQ-034 SHALL test idle drain: a single item is consumed with no new requests -> out_valid=0 the next cycle.
